fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program counter and fetch sequencer at the far end of the control decoder. It drives PC to the
//  instruction ROM and takes BranchEn/ConditionBranch/Halt/RegSet back from the decoder.
//  It also generates IsLoadingReg, which marks the literal word that follows a RegSet instruction.
//  It owns the run/halt state of the core.
// PARAMETERS
//  PC_W    10   program counter width; instruction ROM depth = 2**PC_W
//  CNT_W   16   width of TakenCount (used only with FETCH_TAKEN_CNT_EN)
// PORTS
//  Clk              in   1      core clock; all state updates on rising edge
//  ResetN           in   1      asynchronous, active-low reset
//  Start            in   1      begin execution at StartAddr (honoured in IDLE/HALTED only)
//  StartAddr        in   PC_W   first instruction address
//  Stall            in   1      hold PC and state this cycle
//  BranchEn         in   1      decoder: current instr is a branch
//  ConditionBranch  in   1      decoder: branch is conditional
//  CondFlag         in   1      ALU compare flag; a conditional branch is taken when 1
//  Target           in   PC_W   absolute branch target (from branch LUT)
//  Halt             in   1      decoder: halt instruction
//  RegSet           in   1      decoder: next ROM word is a literal
//  PC               out  PC_W   current fetch address
//  IsLoadingReg     out  1      current ROM word is a RegSet literal, not an instruction
//  Running          out  1      state is RUN or LOADREG
//  Done             out  1      state is HALTED; held until next Start
//  TakenCount       out  CNT_W  taken-branch count (only with FETCH_TAKEN_CNT_EN)
// BEHAVIOUR
//  Reset (ResetN=0, async): state=IDLE, PC=0, IsLoadingReg=0, Running=0, Done=0, TakenCount=0.
//  All outputs are registered or decoded from the state register; there is no comb path from inputs.
//  States: IDLE, RUN, LOADREG, HALTED.
//   IDLE:    Start=1 -> PC<=StartAddr, RUN. Other inputs ignored.
//   RUN:     Stall=1 -> hold everything (priority over all control inputs).
//            Otherwise one action per edge, in this priority order:
//            Halt=1 -> HALTED, PC held (points at the halt instruction).
//            BranchEn & (~ConditionBranch | CondFlag) -> PC<=Target (taken).
//            BranchEn & ConditionBranch & ~CondFlag -> PC<=PC+1 (not taken).
//            RegSet=1 -> PC<=PC+1, LOADREG.
//            else PC<=PC+1.
//            Branch and RegSet never assert together; if they do, the branch wins and RegSet is dropped.
//   LOADREG: IsLoadingReg=1. Stall=1 -> hold. Else PC<=PC+1, RUN.
//            Halt/BranchEn/RegSet are ignored here; the decoder already gates them.
//            A RegSet literal never re-triggers LOADREG.
//   HALTED:  Done=1. Start=1 -> Done=0, PC<=StartAddr, RUN. Stall has no effect in HALTED.
//  Start in RUN or LOADREG is ignored; there is no restart mid-program.
//  Latency: the control inputs of the word at PC in cycle n determine PC in cycle n+1.
//  Branch penalty is zero: single-cycle combinational ROM.
//  Arithmetic: PC+1 is modulo 2**PC_W. Increment from all-ones wraps to 0 with no flag.
//  This also applies on the LOADREG exit.
//  Reset mid-operation returns to IDLE immediately, whatever the Stall state.
//  A LOADREG in progress is abandoned.
// CONFIGURATION
//  FETCH_TAKEN_CNT_EN defined:
//   TakenCount increments on every taken branch in RUN with Stall=0. It saturates at all-ones.
//   It clears on reset and on any honoured Start.
//  FETCH_TAKEN_CNT_EN undefined:
//   TakenCount port still exists and is tied to 0. No counter flops are inferred.
// TESTING
//  1. Reset then Start with StartAddr=0x010, no control inputs for 3 cycles -> PC=0x010,0x011,0x012,0x013; Running=1.
//  2. In RUN at PC=0x020: BranchEn=1, ConditionBranch=1, CondFlag=0 -> PC=0x021.
//     Then BranchEn=1, ConditionBranch=1, CondFlag=1, Target=0x100 -> PC=0x100.
//     With the macro defined, TakenCount=1.
//  3. RegSet=1 at PC=0x030 -> next cycle PC=0x031, IsLoadingReg=1.
//     Drive Halt=1 in that cycle -> ignored; PC=0x032, IsLoadingReg=0, RUN.
//  4. Halt=1 at PC=0x040 -> PC stays 0x040, Done=1, Running=0 for 5 cycles.
//     Then Start with StartAddr=0 -> PC=0, Done=0.
//  5. PC=0x3FF (PC_W=10), no control inputs -> PC=0x000.
//     Stall=1 together with Halt=1 -> state stays RUN, PC held.
//  6. Drop ResetN asynchronously mid-LOADREG -> IDLE immediately, with PC=0, IsLoadingReg=0 and TakenCount=0.
//     Start in RUN is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Program counter and fetch sequencer. Drives PC to the instruction ROM,
//   takes branch/halt/literal-load controls back from the decoder, and owns
//   the run/halt state of the core.
//
//   Optional feature macro: FETCH_TAKEN_CNT_EN
//     defined   -> TakenCount counts taken branches (saturating, cleared on
//                  reset and on every honoured Start)
//     undefined -> TakenCount is tied to zero, no counter flops
//
// Ports
//   Clk             in   core clock, rising edge
//   ResetN          in   asynchronous active-low reset
//   Start           in   begin execution at StartAddr (IDLE/HALTED only)
//   StartAddr       in   first instruction address
//   Stall           in   hold PC and state this cycle (no effect in HALTED)
//   BranchEn        in   current instruction is a branch
//   ConditionBranch in   branch is conditional
//   CondFlag        in   ALU compare flag, conditional branch taken when 1
//   Target          in   absolute branch target
//   Halt            in   halt instruction
//   RegSet          in   next ROM word is a literal
//   PC              out  current fetch address
//   IsLoadingReg    out  current ROM word is a RegSet literal
//   Running         out  state is RUN or LOADREG
//   Done            out  state is HALTED
//   TakenCount      out  taken-branch count
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned PC_W  = 10,
   parameter int unsigned CNT_W = 16
) (
   input  logic             Clk,
   input  logic             ResetN,
   input  logic             Start,
   input  logic [PC_W-1:0]  StartAddr,
   input  logic             Stall,
   input  logic             BranchEn,
   input  logic             ConditionBranch,
   input  logic             CondFlag,
   input  logic [PC_W-1:0]  Target,
   input  logic             Halt,
   input  logic             RegSet,
   output logic [PC_W-1:0]  PC,
   output logic             IsLoadingReg,
   output logic             Running,
   output logic             Done,
   output logic [CNT_W-1:0] TakenCount
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_LOADREG = 2'd2,
      ST_HALTED  = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc_q, pc_nxt, pc_inc;

   // Increment wraps modulo 2**PC_W by width truncation.
   assign pc_inc = pc_q + PC_W'(1);

   // State and PC register
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state <= ST_IDLE;
         pc_q  <= '0;
      end else begin
         state <= state_nxt;
         pc_q  <= pc_nxt;
      end
   end

   // Next-state and next-PC logic
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      case (state)
         ST_IDLE, ST_HALTED: begin
            if (Start) begin
               pc_nxt    = StartAddr;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!Stall) begin
               if (Halt) begin
                  state_nxt = ST_HALTED;
               end else if (BranchEn && (!ConditionBranch || CondFlag)) begin
                  pc_nxt = Target;
               end else if (BranchEn) begin
                  pc_nxt = pc_inc;
               end else if (RegSet) begin
                  // Branch and RegSet together: branch arms above win, RegSet dropped.
                  pc_nxt    = pc_inc;
                  state_nxt = ST_LOADREG;
               end else begin
                  pc_nxt = pc_inc;
               end
            end
         end
         ST_LOADREG: begin
            // Decoder controls are meaningless on a literal word; only Stall matters.
            if (!Stall) begin
               pc_nxt    = pc_inc;
               state_nxt = ST_RUN;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            pc_nxt    = '0;
         end
      endcase
   end

   // Outputs decoded from the state register only
   always_comb begin
      PC           = pc_q;
      IsLoadingReg = (state == ST_LOADREG);
      Running      = (state == ST_RUN) || (state == ST_LOADREG);
      Done         = (state == ST_HALTED);
   end

`ifdef FETCH_TAKEN_CNT_EN
   logic             taken;
   logic             start_ok;
   logic [CNT_W-1:0] taken_cnt;

   assign taken    = (state == ST_RUN) && !Stall && !Halt && BranchEn &&
                     (!ConditionBranch || CondFlag);
   assign start_ok = Start && ((state == ST_IDLE) || (state == ST_HALTED));

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         taken_cnt <= '0;
      end else if (start_ok) begin
         taken_cnt <= '0;
      end else if (taken && (taken_cnt != '1)) begin
         taken_cnt <= taken_cnt + CNT_W'(1);
      end
   end

   assign TakenCount = taken_cnt;
`else
   assign TakenCount = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int unsigned PC_W  = 10;
   localparam int unsigned CNT_W = 16;

   logic             Clk;
   logic             ResetN;
   logic             Start;
   logic [PC_W-1:0]  StartAddr;
   logic             Stall;
   logic             BranchEn;
   logic             ConditionBranch;
   logic             CondFlag;
   logic [PC_W-1:0]  Target;
   logic             Halt;
   logic             RegSet;
   logic [PC_W-1:0]  PC;
   logic             IsLoadingReg;
   logic             Running;
   logic             Done;
   logic [CNT_W-1:0] TakenCount;

   fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .ResetN(ResetN), .Start(Start), .StartAddr(StartAddr),
      .Stall(Stall), .BranchEn(BranchEn), .ConditionBranch(ConditionBranch),
      .CondFlag(CondFlag), .Target(Target), .Halt(Halt), .RegSet(RegSet),
      .PC(PC), .IsLoadingReg(IsLoadingReg), .Running(Running), .Done(Done),
      .TakenCount(TakenCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [PC_W-1:0]  pc;
      logic             isl;
      logic             run;
      logic             done;
      logic [CNT_W-1:0] tc;
      string            name;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [CNT_W-1:0] exp_tc(input int v);
`ifdef FETCH_TAKEN_CNT_EN
      return CNT_W'(v);
`else
      return '0;
`endif
   endfunction

   function automatic void compare(input exp_t e);
      checks++;
      if (PC !== e.pc || IsLoadingReg !== e.isl || Running !== e.run ||
          Done !== e.done || TakenCount !== e.tc) begin
         failures++;
         $display("FAIL %s: got PC=%h isl=%b run=%b done=%b tc=%0d, expected PC=%h isl=%b run=%b done=%b tc=%0d",
                  e.name, PC, IsLoadingReg, Running, Done, TakenCount,
                  e.pc, e.isl, e.run, e.done, e.tc);
      end
   endfunction

   // Monitor: every rising edge updates registered outputs; compare just after.
   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare(e);
         end
      end
   end

   task automatic step(input logic st, input logic [PC_W-1:0] sa, input logic stl,
                       input logic br, input logic cb, input logic cf,
                       input logic [PC_W-1:0] tg, input logic hl, input logic rs,
                       input logic [PC_W-1:0] epc, input logic eisl,
                       input logic erun, input logic edone, input int etc,
                       input string nm);
      exp_t e;
      @(negedge Clk);
      Start = st; StartAddr = sa; Stall = stl; BranchEn = br;
      ConditionBranch = cb; CondFlag = cf; Target = tg; Halt = hl; RegSet = rs;
      e.pc = epc; e.isl = eisl; e.run = erun; e.done = edone;
      e.tc = exp_tc(etc); e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic check_now(input string nm);
      exp_t e;
      e.pc = '0; e.isl = 1'b0; e.run = 1'b0; e.done = 1'b0; e.tc = '0; e.name = nm;
      compare(e);
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      ResetN = 1'b0; Start = 0; StartAddr = '0; Stall = 0; BranchEn = 0;
      ConditionBranch = 0; CondFlag = 0; Target = '0; Halt = 0; RegSet = 0;
      #3;
      check_now("reset_state");
      @(negedge Clk);
      @(negedge Clk);
      ResetN = 1'b1;

      // IDLE ignores everything but Start
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0, 0, 0, "idle_hold");
      step(0, 10'h000, 0, 1, 0, 0, 10'h155, 1, 1, 10'h000, 0, 0, 0, 0, "idle_ignore_ctrl");
      // Start and sequential fetch
      step(1, 10'h010, 0, 0, 0, 0, 10'h000, 0, 0, 10'h010, 0, 1, 0, 0, "start_010");
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 0, 10'h011, 0, 1, 0, 0, "seq_011");
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 0, 10'h012, 0, 1, 0, 0, "seq_012");
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 0, 10'h013, 0, 1, 0, 0, "seq_013");
      step(1, 10'h200, 0, 0, 0, 0, 10'h000, 0, 0, 10'h014, 0, 1, 0, 0, "start_in_run_ignored");
      // Branches
      step(0, 10'h000, 0, 1, 0, 0, 10'h020, 0, 0, 10'h020, 0, 1, 0, 1, "uncond_branch_020");
      step(0, 10'h000, 0, 1, 1, 0, 10'h300, 0, 0, 10'h021, 0, 1, 0, 1, "cond_not_taken");
      step(0, 10'h000, 0, 1, 1, 1, 10'h100, 0, 0, 10'h100, 0, 1, 0, 2, "cond_taken_100");
      step(0, 10'h000, 1, 1, 0, 0, 10'h3FE, 0, 0, 10'h100, 0, 1, 0, 2, "stall_over_branch");
      step(0, 10'h000, 0, 1, 0, 0, 10'h030, 0, 1, 10'h030, 0, 1, 0, 3, "branch_beats_regset");
      // RegSet / LOADREG
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 1, 10'h031, 1, 1, 0, 3, "regset_enter");
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 1, 0, 10'h032, 0, 1, 0, 3, "loadreg_halt_ignored");
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 1, 10'h033, 1, 1, 0, 3, "regset_again");
      step(0, 10'h000, 1, 0, 0, 0, 10'h000, 0, 0, 10'h033, 1, 1, 0, 3, "loadreg_stall");
      step(0, 10'h000, 0, 1, 0, 0, 10'h222, 0, 1, 10'h034, 0, 1, 0, 3, "loadreg_ctrl_ignored");
      // Halt
      step(0, 10'h000, 0, 1, 0, 0, 10'h040, 0, 0, 10'h040, 0, 1, 0, 4, "branch_040");
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 1, 0, 10'h040, 0, 0, 1, 4, "halt_enter");
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 0, 10'h040, 0, 0, 1, 4, "halted_1");
      step(0, 10'h000, 1, 0, 0, 0, 10'h000, 0, 0, 10'h040, 0, 0, 1, 4, "halted_stall");
      step(0, 10'h000, 0, 1, 0, 0, 10'h123, 0, 1, 10'h040, 0, 0, 1, 4, "halted_ctrl");
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 1, 0, 10'h040, 0, 0, 1, 4, "halted_4");
      step(1, 10'h000, 0, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 1, 0, 0, "restart_0");
      // Wrap
      step(0, 10'h000, 0, 1, 0, 0, 10'h3FE, 0, 0, 10'h3FE, 0, 1, 0, 1, "branch_3FE");
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 0, 10'h3FF, 0, 1, 0, 1, "seq_3FF");
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 1, 0, 1, "wrap_000");
      step(0, 10'h000, 0, 1, 0, 0, 10'h3FE, 0, 0, 10'h3FE, 0, 1, 0, 2, "branch_3FE_b");
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 1, 10'h3FF, 1, 1, 0, 2, "regset_at_3FE");
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 1, 0, 2, "loadreg_exit_wrap");
      // Stall with Halt keeps RUN
      step(0, 10'h000, 1, 0, 0, 0, 10'h000, 1, 0, 10'h000, 0, 1, 0, 2, "stall_over_halt");
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 0, 10'h001, 0, 1, 0, 2, "still_run");
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 1, 10'h002, 1, 1, 0, 2, "regset_before_reset");

      // Asynchronous reset mid-LOADREG, between clock edges
      @(negedge Clk);
      Stall = 1'b1; RegSet = 1'b0;
      #2;
      ResetN = 1'b0;
      #1;
      check_now("async_reset_loadreg");
      @(negedge Clk);
      ResetN = 1'b1;
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0, 0, 0, "idle_after_reset");
      step(1, 10'h155, 0, 0, 0, 0, 10'h000, 0, 0, 10'h155, 0, 1, 0, 0, "start_155");
      step(0, 10'h000, 0, 0, 0, 0, 10'h000, 0, 0, 10'h156, 0, 1, 0, 0, "seq_156");

      // Drain the scoreboard with a bound
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
